// File: rtl/ddr4_phy_pkg.sv
// Shared types and constants for the DDRPHY lane sequencers.
// Holds the sequencer state encodings, IOD nibble values and default JEDEC cycle counts.
package ddr4_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DLY_LOAD,
        ST_DLY_MOVE,
        ST_DLY_GAP,
        ST_RST_HOLD,
        ST_RST_REL,
        ST_CKE_ON
    } seq_state_t;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_LOAD,
        DS_MOVE,
        DS_GAP
    } dly_state_t;

    localparam logic [3:0] TX_NIBBLE_LOW   = 4'b0000;
    localparam logic [3:0] TX_NIBBLE_HIGH  = 4'b1111;
    localparam logic [3:0] OE_NIBBLE_DRIVE = 4'b1111;

    // 200 us and 500 us at a 200 MHz fabric clock.
    localparam int T_RESET_CYC_DEFAULT = 40000;
    localparam int T_CKE_CYC_DEFAULT   = 100000;
    localparam int DLY_W_DEFAULT       = 8;
    localparam int CNT_W_DEFAULT       = 17;

    function automatic logic [3:0] tx_nibble(input logic release_pin);
        return release_pin ? TX_NIBBLE_HIGH : TX_NIBBLE_LOW;
    endfunction

endpackage

// File: rtl/dly_line_stepper.sv
// Delay-line LOAD/MOVE/GAP handshake: one LOAD, then MOVE pulses two cycles apart until the
// tap target is reached or the IOD reports out-of-range. Shared with the DQ/DQS lanes.
module dly_line_stepper
    import ddr4_phy_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [DLY_W-1:0] i_target,
    input  logic             i_dir,
    input  logic             i_out_of_range,
    output logic             o_load,
    output logic             o_move,
    output logic             o_dir,
    output logic             o_err,
    output logic             o_done
);

    dly_state_t       r_state;
    logic [DLY_W-1:0] r_target;
    logic [DLY_W-1:0] r_tap;
    logic             r_load;
    logic             r_move;
    logic             r_dir;
    logic             r_err;
    logic             w_done;

    // Combinational so the caller leaves its delay phase in the same cycle as this block.
    assign w_done = ((r_state == DS_LOAD) && (r_target == '0)) ||
                    ((r_state == DS_GAP) && (i_out_of_range || (r_tap == r_target)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= DS_IDLE;
            r_target <= '0;
            r_tap    <= '0;
            r_load   <= 1'b0;
            r_move   <= 1'b0;
            r_dir    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_move <= 1'b0;
            case (r_state)
                DS_IDLE: begin
                    r_state <= DS_IDLE;
                end
                DS_LOAD: begin
                    if (r_target == '0) begin
                        r_state <= DS_IDLE;
                    end else begin
                        r_state <= DS_MOVE;
                        r_move  <= 1'b1;
                    end
                end
                DS_MOVE: begin
                    r_tap   <= r_tap + DLY_W'(1);
                    r_state <= DS_GAP;
                end
                DS_GAP: begin
                    if (i_out_of_range) begin
                        r_err   <= 1'b1;
                        r_state <= DS_IDLE;
                    end else if (r_tap == r_target) begin
                        r_state <= DS_IDLE;
                    end else begin
                        r_state <= DS_MOVE;
                        r_move  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= DS_IDLE;
                end
            endcase
            // A start restarts the handshake from any state; the caller gates it.
            if (i_start) begin
                r_state  <= DS_LOAD;
                r_load   <= 1'b1;
                r_move   <= 1'b0;
                r_target <= i_target;
                r_dir    <= i_dir;
                r_err    <= 1'b0;
                r_tap    <= '0;
            end
        end
    end

    assign o_load = r_load;
    assign o_move = r_move;
    assign o_dir  = r_dir;
    assign o_err  = r_err;
    assign o_done = w_done;

endmodule

// File: rtl/ddr4_reset_n_seq_ctrl.sv
// DDR4 RESET_N power-up sequencer: delay-line setup, RESET_N low for tRESET, release,
// then CKE_EN after tRESET_CKE. RESET_N is never tristated and all TX bits switch together.
module ddr4_reset_n_seq_ctrl
    import ddr4_phy_pkg::*;
#(
    parameter int T_RESET_CYC = T_RESET_CYC_DEFAULT,
    parameter int T_CKE_CYC   = T_CKE_CYC_DEFAULT,
    parameter int DLY_W       = DLY_W_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             FAB_CLK,
    input  logic             ARST,
    input  logic             START,
    input  logic [DLY_W-1:0] DLY_TARGET,
    input  logic             DLY_DIR,
    output logic [3:0]       TX_DATA_0,
    output logic [3:0]       OE_DATA_0,
    output logic             ODT_EN_0,
    output logic             DELAY_LINE_LOAD_0,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0,
    output logic             CKE_EN,
    output logic             BUSY,
    output logic             DONE,
    output logic             DLY_ERR
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(T_RESET_CYC - 1);
    localparam logic [CNT_W-1:0] CKE_LAST  = CNT_W'(T_CKE_CYC - 1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tx_release;
    logic             r_cke_en;
    logic             r_busy;
    logic             r_done;
    logic             w_accept;
    logic             w_step_done;

    assign w_accept = START && ((r_state == ST_IDLE) || (r_state == ST_CKE_ON));

    dly_line_stepper #(
        .DLY_W (DLY_W)
    ) u_stepper (
        .i_clk          (FAB_CLK),
        .i_rst          (ARST),
        .i_start        (w_accept),
        .i_target       (DLY_TARGET),
        .i_dir          (DLY_DIR),
        .i_out_of_range (DELAY_LINE_OUT_OF_RANGE_0),
        .o_load         (DELAY_LINE_LOAD_0),
        .o_move         (DELAY_LINE_MOVE_0),
        .o_dir          (DELAY_LINE_DIRECTION_0),
        .o_err          (DLY_ERR),
        .o_done         (w_step_done)
    );

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_tx_release <= 1'b0;
            r_cke_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_CKE_ON: begin
                    if (w_accept) begin
                        // Restart from CKE_ON is a full re-reset: RESET_N goes low again.
                        r_state      <= ST_DLY_LOAD;
                        r_cnt        <= '0;
                        r_tx_release <= 1'b0;
                        r_cke_en     <= 1'b0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                // The delay states shadow the stepper, which owns LOAD/MOVE timing.
                ST_DLY_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= w_step_done ? ST_RST_HOLD : ST_DLY_MOVE;
                end
                ST_DLY_MOVE: begin
                    r_state <= ST_DLY_GAP;
                end
                ST_DLY_GAP: begin
                    r_cnt   <= '0;
                    r_state <= w_step_done ? ST_RST_HOLD : ST_DLY_MOVE;
                end
                ST_RST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state      <= ST_RST_REL;
                        r_cnt        <= '0;
                        r_tx_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RST_REL: begin
                    if (r_cnt == CKE_LAST) begin
                        r_state  <= ST_CKE_ON;
                        r_cnt    <= '0;
                        r_cke_en <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cnt        <= '0;
                    r_tx_release <= 1'b0;
                    r_cke_en     <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign TX_DATA_0 = tx_nibble(r_tx_release);
    assign OE_DATA_0 = OE_NIBBLE_DRIVE;
    assign ODT_EN_0  = 1'b0;
    assign CKE_EN    = r_cke_en;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

endmodule

// File: tb/tb_ddr4_reset_n_seq_ctrl.sv
// Bench for ddr4_reset_n_seq_ctrl: a negedge monitor compares observed output edges
// against a queue of expected (event, cycle) pairs pushed when each START is driven.
module tb_ddr4_reset_n_seq_ctrl;

    localparam int TR = 10;
    localparam int TC = 20;

    typedef enum {EV_TX_LO, EV_CKE_LO, EV_LOAD, EV_MOVE, EV_TX_HI, EV_CKE_HI} ev_t;
    typedef struct {
        ev_t kind;
        int  cyc;
    } exp_t;

    logic       FAB_CLK = 1'b0;
    logic       ARST = 1'b0;
    logic       START = 1'b0;
    logic [7:0] DLY_TARGET = 8'd0;
    logic       DLY_DIR = 1'b0;
    logic       OOR = 1'b0;
    logic [3:0] TX_DATA_0;
    logic [3:0] OE_DATA_0;
    logic       ODT_EN_0;
    logic       LOAD;
    logic       MOVE;
    logic       DIR;
    logic       CKE_EN;
    logic       BUSY;
    logic       DONE;
    logic       DLY_ERR;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   oor_after = 0;
    int   mv_cnt = 0;
    logic exp_dir = 1'b0;
    exp_t exp_q[$];
    ev_t  got_q[$];
    exp_t e;
    logic [3:0] p_tx = 4'hx;
    logic p_cke = 1'bx, p_load = 1'bx, p_move = 1'bx;

    ddr4_reset_n_seq_ctrl #(
        .T_RESET_CYC (TR),
        .T_CKE_CYC   (TC),
        .DLY_W       (8),
        .CNT_W       (17)
    ) dut (
        .FAB_CLK                   (FAB_CLK),
        .ARST                      (ARST),
        .START                     (START),
        .DLY_TARGET                (DLY_TARGET),
        .DLY_DIR                   (DLY_DIR),
        .TX_DATA_0                 (TX_DATA_0),
        .OE_DATA_0                 (OE_DATA_0),
        .ODT_EN_0                  (ODT_EN_0),
        .DELAY_LINE_LOAD_0         (LOAD),
        .DELAY_LINE_MOVE_0         (MOVE),
        .DELAY_LINE_DIRECTION_0    (DIR),
        .DELAY_LINE_OUT_OF_RANGE_0 (OOR),
        .CKE_EN                    (CKE_EN),
        .BUSY                      (BUSY),
        .DONE                      (DONE),
        .DLY_ERR                   (DLY_ERR)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    always @(posedge FAB_CLK) cyc <= cyc + 1;

    // Scoreboard monitor: edges are listed in a fixed order so same-cycle events line up.
    always @(negedge FAB_CLK) begin
        got_q.delete();
        if (mon_en) begin
            if (TX_DATA_0 === 4'h0 && p_tx === 4'hF) got_q.push_back(EV_TX_LO);
            if (CKE_EN === 1'b0 && p_cke === 1'b1)   got_q.push_back(EV_CKE_LO);
            if (LOAD === 1'b1 && p_load === 1'b0)    got_q.push_back(EV_LOAD);
            if (MOVE === 1'b1 && p_move === 1'b0)    got_q.push_back(EV_MOVE);
            if (TX_DATA_0 === 4'hF && p_tx === 4'h0) got_q.push_back(EV_TX_HI);
            if (CKE_EN === 1'b1 && p_cke === 1'b0)   got_q.push_back(EV_CKE_HI);
            foreach (got_q[i]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_event got=%s@%0d required=none", got_q[i].name(), cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != got_q[i] || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL sb_event got=%s@%0d required=%s@%0d",
                                 got_q[i].name(), cyc, e.kind.name(), e.cyc);
                    end
                end
                if (got_q[i] == EV_MOVE) begin
                    checks++;
                    if (DIR !== exp_dir) begin
                        errors++;
                        $display("FAIL move_dir got=%b required=%b @%0d", DIR, exp_dir, cyc);
                    end
                end
            end
        end
        if (LOAD === 1'b1) mv_cnt = 0;
        if (MOVE === 1'b1 && p_move === 1'b0) mv_cnt++;
        OOR = (oor_after != 0) && (mv_cnt >= oor_after);
        p_tx = TX_DATA_0;
        p_cke = CKE_EN;
        p_load = LOAD;
        p_move = MOVE;
    end

    task automatic start_seq(input logic [7:0] tgt, input logic dir, input int n_mv,
                             input bit restart, input int oor_at);
        int p0;
        int h;
        @(negedge FAB_CLK);
        p0 = cyc + 1;
        if (restart) begin
            exp_q.push_back(exp_t'{EV_TX_LO, p0});
            exp_q.push_back(exp_t'{EV_CKE_LO, p0});
        end
        exp_q.push_back(exp_t'{EV_LOAD, p0});
        for (int k = 0; k < n_mv; k++) exp_q.push_back(exp_t'{EV_MOVE, p0 + 1 + 2 * k});
        h = p0 + 2 * n_mv + 1;
        exp_q.push_back(exp_t'{EV_TX_HI, h + TR});
        exp_q.push_back(exp_t'{EV_CKE_HI, h + TR + TC});
        exp_dir = dir;
        oor_after = oor_at;
        DLY_TARGET = tgt;
        DLY_DIR = dir;
        START = 1'b1;
        @(negedge FAB_CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge FAB_CLK);
            if (DONE === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge FAB_CLK);
        #1;
    endtask

    task automatic wait_tx_high(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge FAB_CLK);
            if (TX_DATA_0 === 4'hF) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        ARST = 1'b1;
        repeat (3) @(negedge FAB_CLK);
        ARST = 1'b0;
        repeat (5) @(negedge FAB_CLK);
        mon_en = 1'b1;
        checks++; if (TX_DATA_0 !== 4'h0) begin errors++; $display("FAIL rst_tx got=%h required=0", TX_DATA_0); end
        checks++; if (OE_DATA_0 !== 4'hF) begin errors++; $display("FAIL rst_oe got=%h required=f", OE_DATA_0); end
        checks++; if (ODT_EN_0 !== 1'b0) begin errors++; $display("FAIL rst_odt got=%b required=0", ODT_EN_0); end
        checks++; if (CKE_EN !== 1'b0) begin errors++; $display("FAIL rst_cke got=%b required=0", CKE_EN); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b required=0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_done got=%b required=0", DONE); end
        checks++; if (DLY_ERR !== 1'b0) begin errors++; $display("FAIL rst_err got=%b required=0", DLY_ERR); end
        checks++;
        if ({LOAD, MOVE, DIR} !== 3'b000) begin
            errors++; $display("FAIL rst_dly got=%b required=000", {LOAD, MOVE, DIR});
        end
    endtask

    task automatic test_basic();
        bit ok;
        start_seq(8'd3, 1'b1, 3, 1'b0, 0);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b required=1", BUSY); end
        checks++; if (TX_DATA_0 !== 4'h0) begin errors++; $display("FAIL basic_tx_low got=%h required=0", TX_DATA_0); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=no_done required=done"); end
        checks++; if (CKE_EN !== 1'b1) begin errors++; $display("FAIL basic_cke got=%b required=1", CKE_EN); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b required=0", BUSY); end
        checks++; if (DLY_ERR !== 1'b0) begin errors++; $display("FAIL basic_err got=%b required=0", DLY_ERR); end
        checks++; if (TX_DATA_0 !== 4'hF) begin errors++; $display("FAIL basic_tx_high got=%h required=f", TX_DATA_0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_zero_target();
        bit ok;
        start_seq(8'd0, 1'b1, 0, 1'b1, 0);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_timeout got=no_done required=done"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zero_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_out_of_range();
        bit ok;
        start_seq(8'd8, 1'b0, 2, 1'b1, 2);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL oor_timeout got=no_done required=done"); end
        checks++; if (DLY_ERR !== 1'b1) begin errors++; $display("FAIL oor_err got=%b required=1", DLY_ERR); end
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL oor_done got=%b required=1", DONE); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL oor_pending got=%0d required=0", exp_q.size()); end
        oor_after = 0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        start_seq(8'd1, 1'b0, 1, 1'b1, 0);
        wait_tx_high(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_tx_timeout got=no_release required=release"); end
        repeat (3) @(negedge FAB_CLK);
        START = 1'b1;
        @(negedge FAB_CLK);
        START = 1'b0;
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_ignore_busy got=%b required=1", BUSY); end
        checks++; if (TX_DATA_0 !== 4'hF) begin errors++; $display("FAIL b2b_ignore_tx got=%h required=f", TX_DATA_0); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got=no_done required=done"); end
        checks++; if (DLY_ERR !== 1'b0) begin errors++; $display("FAIL b2b_err_clear got=%b required=0", DLY_ERR); end
        start_seq(8'd2, 1'b1, 2, 1'b1, 0);
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL restart_done got=%b required=0", DONE); end
        checks++; if (CKE_EN !== 1'b0) begin errors++; $display("FAIL restart_cke got=%b required=0", CKE_EN); end
        checks++; if (TX_DATA_0 !== 4'h0) begin errors++; $display("FAIL restart_tx got=%h required=0", TX_DATA_0); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL restart_timeout got=no_done required=done"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        bit ok;
        start_seq(8'd4, 1'b1, 1, 1'b1, 1);
        wait_tx_high(ok);
        checks++; if (!ok) begin errors++; $display("FAIL arst_tx_timeout got=no_release required=release"); end
        repeat (3) @(negedge FAB_CLK);
        checks++; if (DLY_ERR !== 1'b1) begin errors++; $display("FAIL arst_err_pre got=%b required=1", DLY_ERR); end
        oor_after = 0;
        @(posedge FAB_CLK);
        #2;
        checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL arst_pending got=%0d required=1", exp_q.size()); end
        exp_q.delete();
        exp_q.push_back(exp_t'{EV_TX_LO, cyc});
        ARST = 1'b1;
        #1;
        checks++; if (TX_DATA_0 !== 4'h0) begin errors++; $display("FAIL arst_tx got=%h required=0", TX_DATA_0); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b required=0", BUSY); end
        checks++; if (DLY_ERR !== 1'b0) begin errors++; $display("FAIL arst_err got=%b required=0", DLY_ERR); end
        @(negedge FAB_CLK);
        #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL arst_tx_event got=%0d required=0", exp_q.size()); end
        ARST = 1'b0;
        repeat (2) @(negedge FAB_CLK);
        start_seq(8'd2, 1'b1, 2, 1'b0, 0);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rerun_timeout got=no_done required=done"); end
        checks++; if (DLY_ERR !== 1'b0) begin errors++; $display("FAIL rerun_err got=%b required=0", DLY_ERR); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rerun_pending got=%0d required=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_target();
        test_out_of_range();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr4_reset_n_seq_ctrl.md
Name: ddr4_reset_n_seq_ctrl

Overview:
Power-up sequencer for the DDR4 RESET_N output lane of the DDRPHY block. It first configures the lane's dynamic output delay line (load, then step to a target tap). It then drives the 4-bit TX_DATA/OE_DATA nibble fed to the RESET_N IOD so that RESET_N is held low for tRESET, then released. After tRESET_CKE it raises CKE_EN to the CKE/command path. It sits in the DDRPHY block between the training/init controller and the RESET_N IOD wrapper.

Parameters:
T_RESET_CYC, 40000, FAB_CLK cycles RESET_N is held low (200 us at 200 MHz); must be ≥2.
T_CKE_CYC, 100000, FAB_CLK cycles from RESET_N release to CKE_EN assertion (500 us); must be ≥2.
DLY_W, 8, width of the delay tap target and tap counter.
CNT_W, 17, width of the timing counter; must satisfy 2^CNT_W > max(T_RESET_CYC, T_CKE_CYC).

Ports:
FAB_CLK  in  1  fabric clock; all logic sits on its rising edge.
ARST  in  1  asynchronous reset, active-high.
START  in  1  single-cycle request to begin or restart the sequence.
DLY_TARGET  in  DLY_W  number of delay-line MOVE steps to apply after LOAD; sampled on accepted START.
DLY_DIR  in  1  delay-line direction for all MOVE steps; sampled on accepted START.
TX_DATA_0  out  4  RESET_N serialized data nibble to the IOD.
OE_DATA_0  out  4  output-enable nibble to the IOD.
ODT_EN_0  out  1  ODT enable to the IOD; constant 0.
DELAY_LINE_LOAD_0  out  1  delay-line load pulse.
DELAY_LINE_MOVE_0  out  1  delay-line move pulse.
DELAY_LINE_DIRECTION_0  out  1  delay-line direction.
DELAY_LINE_OUT_OF_RANGE_0  in  1  delay-line limit flag from the IOD.
CKE_EN  out  1  permits the CKE path to drive CKE high.
BUSY  out  1  1 in any state other than IDLE or DONE.
DONE  out  1  sequence complete.
DLY_ERR  out  1  sticky flag: OUT_OF_RANGE was seen during stepping; cleared on accepted START.

Behaviour:
- Clock and reset: one clock (FAB_CLK). ARST is asynchronous and active-high.
- Reset values: state IDLE; TX_DATA_0 = 4'b0000 (RESET_N low); OE_DATA_0 = 4'b1111 (pin driven); ODT_EN_0 = 0; LOAD, MOVE and DIRECTION = 0; CKE_EN = 0; BUSY = 0; DONE = 0; DLY_ERR = 0; all counters 0.
- OE_DATA_0 is 4'b1111 in every state. RESET_N is never tristated.
- TX_DATA_0 is 4'b1111 only in the RST_REL and CKE_ON states; it is 4'b0000 in every other state. All four bits are always equal, so there are no intra-cycle glitches.
- FSM states: IDLE, DLY_LOAD, DLY_MOVE, DLY_GAP, RST_HOLD, RST_REL, CKE_ON.
  - IDLE:
    - On START: capture DLY_TARGET and DLY_DIR, clear DLY_ERR and DONE, go to DLY_LOAD.
  - DLY_LOAD:
    - LOAD = 1 for exactly one cycle.
    - If the captured target is 0, go to RST_HOLD. Otherwise go to DLY_MOVE.
  - DLY_MOVE:
    - MOVE = 1 for one cycle; DIRECTION = captured DLY_DIR (held stable through the whole DLY_ phase); tap counter += 1.
    - Go to DLY_GAP.
  - DLY_GAP:
    - MOVE = 0. MOVE pulses are therefore at least 2 cycles apart.
    - If OUT_OF_RANGE = 1: set DLY_ERR and go to RST_HOLD. Stepping is abandoned but the sequence continues.
    - Else if tap counter == target: go to RST_HOLD.
    - Else: go to DLY_MOVE.
  - RST_HOLD:
    - The timing counter counts from 0 to T_RESET_CYC-1, then the FSM goes to RST_REL with the counter cleared.
    - RESET_N is low for exactly T_RESET_CYC cycles in this state (plus the DLY_ cycles before it).
  - RST_REL:
    - The timing counter counts from 0 to T_CKE_CYC-1, then the FSM goes to CKE_ON.
  - CKE_ON:
    - CKE_EN = 1 and DONE = 1, both registered and held.
- Restart: START in CKE_ON behaves as START in IDLE.
  - CKE_EN and DONE drop in the next cycle and the sequence reruns.
  - RESET_N goes low again; this is a full re-reset, per the JEDEC reset-while-powered requirement.
- START while BUSY is ignored; no queuing.
- OUT_OF_RANGE is sampled only in DLY_GAP. If it is already 1 at LOAD, it is still checked after the first MOVE.
- Simultaneous ARST and START: ARST wins.
- ARST mid-sequence: outputs take their reset values immediately (asynchronous) and RESET_N returns low.
- Counters never wrap: exit comparisons use ==, and each counter clears on state entry.

Decomposition:
- Shared package ddr4_phy_pkg holds:
  - the state enum type;
  - constants TX_NIBBLE_LOW = 4'b0000, TX_NIBBLE_HIGH = 4'b1111 and OE_NIBBLE_DRIVE = 4'b1111;
  - default JEDEC cycle-count constants.
- One sub-module is natural: dly_line_stepper, which implements the LOAD/MOVE/GAP handshake with the tap counter and error flag. It is reused by the DQ/DQS lanes. The top-level FSM waits on its done output.

Test Plan:
1. Test parameters T_RESET_CYC = 10, T_CKE_CYC = 20. ARST pulse, then idle 5 cycles → TX_DATA_0 = 0000, OE_DATA_0 = 1111, CKE_EN = 0, BUSY = 0.
2. START with DLY_TARGET = 3, DLY_DIR = 1 →
   - one LOAD pulse, then 3 MOVE pulses 2 cycles apart with DIRECTION = 1;
   - TX_DATA_0 = 0000 for 10 cycles after the stepping ends, then 1111;
   - CKE_EN = 1 and DONE = 1 exactly 20 cycles after the 1111 edge; DLY_ERR = 0.
3. DLY_TARGET = 0 → LOAD pulse only, no MOVE pulses, RST_HOLD is entered the next cycle.
4. DLY_TARGET = 8, OUT_OF_RANGE forced to 1 after the 2nd MOVE → exactly 2 MOVE pulses, DLY_ERR = 1, reset timing continues, DONE = 1.
5. START pulsed during RST_REL → ignored, CKE_EN timing unchanged. START in CKE_ON → CKE_EN and DONE drop the next cycle, TX_DATA_0 returns to 0000, full resequence runs.
6. ARST asserted mid-RST_REL → TX_DATA_0 goes to 0000 asynchronously, BUSY = 0. A later START reruns the sequence with DLY_ERR cleared.
